// File: rtl/ula_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : ula_seq_if
//  Purpose  : Handshake/operand/result bundle between the control FSM
//             (master) and the registered ALU ula_seq (slave).
//  Signals  : start, sel[3:0], data_in_1, data_in_2   (master -> slave)
//             data_out, nz_out[1:0], c_out, v_out,
//             busy, done                               (slave -> master)
//  Revision : 1.0  initial release
// ============================================================================
interface ula_seq_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [3:0]            sel;
  logic [DATA_WIDTH-1:0] data_in_1;
  logic [DATA_WIDTH-1:0] data_in_2;
  logic [DATA_WIDTH-1:0] data_out;
  logic [1:0]            nz_out;
  logic                  c_out;
  logic                  v_out;
  logic                  busy;
  logic                  done;

  modport master (
    output start, sel, data_in_1, data_in_2,
    input  data_out, nz_out, c_out, v_out, busy, done
  );

  modport slave (
    input  start, sel, data_in_1, data_in_2,
    output data_out, nz_out, c_out, v_out, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/ula_seq.sv
`default_nettype none
// ============================================================================
//  Module   : ula_seq
//  Purpose  : Registered Neander ALU with start/done handshake, 4-bit opcode
//             (ADD AND OR NOT LDA SUB SHL SHR [MUL]) and N/Z/C/V flags.
//  Ports    : clk        system clock (rising edge)
//             rst_n      asynchronous active-low reset
//             bus        ula_seq_if.slave: start, sel, data_in_1 (A),
//                        data_in_2 (B) in; data_out, nz_out {N,Z}, c_out,
//                        v_out, busy, done out
//  Options  : ULA_MUL_EN  compiles in the iterative shift-add multiplier
//             (sel=1000). Without it sel=1000 acts as LDA and busy is 0.
//  Revision : 1.0  initial release
// ============================================================================
module ula_seq #(
  parameter int DATA_WIDTH = 8
) (
  input logic      clk,
  input logic      rst_n,
  ula_seq_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_NOT = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;

  localparam int MSB = DATA_WIDTH - 1;

  // ---------------- single-cycle ALU ----------------
  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH:0]   w_dif;
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_c;
  logic                  w_v;

  always_comb begin
    w_sum = {1'b0, bus.data_in_1} + {1'b0, bus.data_in_2};
    // Subtraction as A + ~B + 1 so the carry out means "no borrow".
    w_dif = {1'b0, bus.data_in_1} + {1'b0, ~bus.data_in_2} + {{DATA_WIDTH{1'b0}}, 1'b1};
    w_res = bus.data_in_2;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (bus.sel)
      OP_ADD: begin
        w_res = w_sum[MSB:0];
        w_c   = w_sum[DATA_WIDTH];
        w_v   = (bus.data_in_1[MSB] == bus.data_in_2[MSB]) &&
                (w_sum[MSB] != bus.data_in_1[MSB]);
      end
      OP_AND: w_res = bus.data_in_1 & bus.data_in_2;
      OP_OR:  w_res = bus.data_in_1 | bus.data_in_2;
      OP_NOT: w_res = ~bus.data_in_1;
      OP_SUB: begin
        w_res = w_dif[MSB:0];
        w_c   = w_dif[DATA_WIDTH];
        w_v   = (bus.data_in_1[MSB] != bus.data_in_2[MSB]) &&
                (w_dif[MSB] != bus.data_in_1[MSB]);
      end
      OP_SHL: begin
        w_res = {bus.data_in_1[MSB-1:0], 1'b0};
        w_c   = bus.data_in_1[MSB];
      end
      OP_SHR: begin
        w_res = {1'b0, bus.data_in_1[MSB:1]};
        w_c   = bus.data_in_1[0];
      end
      default: w_res = bus.data_in_2;   // LDA, and every unused opcode
    endcase
  end

  // Result-register write port, driven by whichever path completes an op.
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_load_res;
  logic                  w_load_c;
  logic                  w_load_v;
  logic                  w_busy_nxt;

  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_nz;
  logic                  r_c;
  logic                  r_v;
  logic                  r_done;
  logic                  r_busy;

`ifdef ULA_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam int         CNT_W  = $clog2(DATA_WIDTH + 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t                  r_state, w_state_nxt;
  logic [2*DATA_WIDTH-1:0] r_a, w_a_nxt;      // multiplicand, shifts left
  logic [DATA_WIDTH-1:0]   r_b, w_b_nxt;      // multiplier, shifts right
  logic [2*DATA_WIDTH-1:0] r_acc, w_acc_nxt;
  logic [2*DATA_WIDTH-1:0] w_acc_add;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_load_res  = w_res;
    w_load_c    = w_c;
    w_load_v    = w_v;
    w_busy_nxt  = 1'b0;
    w_acc_add   = r_acc + (r_b[0] ? r_a : '0);
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.sel == OP_MUL) begin
            w_state_nxt = S_MUL;
            w_a_nxt     = {{DATA_WIDTH{1'b0}}, bus.data_in_1};
            w_b_nxt     = bus.data_in_2;
            w_acc_nxt   = '0;
            w_cnt_nxt   = CNT_W'(DATA_WIDTH);
            w_busy_nxt  = 1'b1;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      S_MUL: begin
        // start is deliberately not looked at here, even on the last step.
        w_acc_nxt  = w_acc_add;
        w_a_nxt    = r_a << 1;
        w_b_nxt    = r_b >> 1;
        w_cnt_nxt  = r_cnt - CNT_W'(1);
        w_busy_nxt = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_load      = 1'b1;
          w_load_res  = w_acc_add[MSB:0];
          w_load_c    = |w_acc_add[2*DATA_WIDTH-1:DATA_WIDTH];
          w_load_v    = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
`else
  always_comb begin
    w_load     = bus.start;
    w_load_res = w_res;
    w_load_c   = w_c;
    w_load_v   = w_v;
    w_busy_nxt = 1'b0;
  end
`endif

  // ---------------- result / flag registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_nz   <= 2'b00;
      r_c    <= 1'b0;
      r_v    <= 1'b0;
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_done <= w_load;
      r_busy <= w_busy_nxt;
      if (w_load) begin
        r_data <= w_load_res;
        r_nz   <= {w_load_res[MSB], ~|w_load_res};
        r_c    <= w_load_c;
        r_v    <= w_load_v;
      end
    end
  end

  assign bus.data_out = r_data;
  assign bus.nz_out   = r_nz;
  assign bus.c_out    = r_c;
  assign bus.v_out    = r_v;
  assign bus.done     = r_done;
  assign bus.busy     = r_busy;

endmodule
`default_nettype wire
